gate_counter_ctrl: RTL and testbench

GATE_COUNTER_CTRL -- requirements
Module: gate_counter_ctrl

---
 rtl/gate_counter_pkg.sv | 14 +
 rtl/edge_sync.sv | 29 ++
 rtl/gate_counter_ctrl.sv | 99 +++++++++
 tb/tb_gate_counter_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_counter_pkg.sv
// Shared definitions for the gate-window pulse counter: state encoding and
// default widths.
package gate_counter_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int WIN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for the asynchronous pulse input, followed by a
// rising-edge detector on the synchronised signal.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic rise
);

    logic sync0_reg;
    logic sync1_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_reg <= 1'b0;
            sync1_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync0_reg <= in;
            sync1_reg <= sync0_reg;
            prev_reg  <= sync1_reg;
        end
    end

    // Pulse is one cycle wide; it is consumed by the FSM at the following edge.
    assign rise = sync1_reg & ~prev_reg;

endmodule

// File: rtl/gate_counter_ctrl.sv
// Gate-window pulse counter: counts rising edges of 'in' over win_len cycles,
// then holds the result with valid until the consumer acknowledges it.
module gate_counter_ctrl
    import gate_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             in,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    state_t             state_reg,    state_next;
    logic [WIN_W-1:0]   timer_reg,    timer_next;
    logic [CNT_W-1:0]   count_reg,    count_next;
    logic               overflow_reg, overflow_next;
    logic               rise;

    edge_sync u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    count_next    = '0;
                    overflow_next = 1'b0;
                    if (win_len != '0) begin
                        timer_next = win_len;
                        state_next = COUNT;
                    end else begin
                        timer_next = '0;
                        state_next = DONE;
                    end
                end
            end
            COUNT: begin
                if (rise) begin
                    if (count_reg == '1) begin
                        overflow_next = 1'b1;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
                // Timer holds the cycles left including this one; never wraps.
                if (timer_reg <= WIN_W'(1)) begin
                    timer_next = '0;
                    state_next = DONE;
                end else begin
                    timer_next = timer_reg - WIN_W'(1);
                end
            end
            DONE: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign valid    = (state_reg == DONE);
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_gate_counter_ctrl.sv
// Scoreboard bench for gate_counter_ctrl: stimulus pushes model results,
// a negedge monitor pops and checks them whenever a result becomes valid.
module tb_gate_counter_ctrl;

    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PAT_N = 512;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             in;
    logic             ack;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             busy;
    logic             overflow;

    gate_counter_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .win_len  (win_len),
        .in       (in),
        .ack      (ack),
        .count    (count),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int o;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   pat[PAT_N];
    logic ack_pos = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pv(input int k);
        return (k < 0) ? 1'b0 : pat[k];
    endfunction

    // Reference: a rise reaching the counter at edge m reflects 'in' held
    // before edges m-2 (high) and m-3 (low); only edges S+1..S+wl count.
    task automatic model(input int s, input int wl, output int c, output int o);
        c = 0;
        o = 0;
        for (int m = s + 1; m <= s + wl; m++) begin
            if (pv(m - 2) && !pv(m - 3)) begin
                if (c == CNT_MAX) o = 1;
                else c++;
            end
        end
    endtask

    task automatic clear_pat();
        for (int i = 0; i < PAT_N; i++) pat[i] = 1'b0;
    endtask

    task automatic set_pulses(input int first, input int n);
        for (int p = 0; p < n; p++) begin
            pat[first + 4*p]     = 1'b1;
            pat[first + 4*p + 1] = 1'b1;
        end
    endtask

    task automatic run_txn(input int s, input int wl, input int ack_dly,
                           input bit noisy, input bit rel_rst);
        exp_t e;
        bit   got;
        model(s, wl, e.c, e.o);
        e.cyc = wl;
        exp_q.push_back(e);
        $display("[TB] txn win_len=%0d start_idx=%0d exp_count=%0d exp_ovf=%0d ack_dly=%0d",
                 wl, s, e.c, e.o, ack_dly);
        got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                break;
            end
            if (rel_rst && i == 0) rst_n = 1'b1;
            in      = (i < PAT_N) ? pat[i] : 1'b0;
            start   = (i == s);
            win_len = (i == s) ? WIN_W'(wl) : WIN_W'($urandom);
        end
        if (!got) begin
            chk("valid_timeout", 0, 1);
            void'(exp_q.pop_back());
            start = 1'b0;
            return;
        end
        for (int d = 0; d < ack_dly; d++) begin
            in    = noisy ? 1'($urandom) : 1'b0;
            start = noisy ? 1'($urandom) : 1'b0;
            win_len = WIN_W'($urandom);
            @(negedge clk);
        end
        ack   = 1'b1;
        start = 1'($urandom);
        in    = 1'b0;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        ack_pos <= ack;
    end

    // Monitor: pops expected results on valid rising, checks hold and release.
    initial begin
        bit   valid_q = 1'b0;
        int   cyc = 0;
        int   held_c = 0;
        int   held_o = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                valid_q = 1'b0;
                cyc = 0;
            end else begin
                if (valid_q && ack_pos) begin
                    chk("ack_valid_low", int'(valid), 0);
                    chk("ack_busy_low", int'(busy), 0);
                end
                if (valid && !valid_q) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("count", int'(count), e.c);
                        chk("overflow", int'(overflow), e.o);
                        chk("count_cycles", cyc, e.cyc);
                        chk("busy_in_done", int'(busy), 1);
                    end
                    held_c = int'(count);
                    held_o = int'(overflow);
                    cyc = 0;
                end else if (valid && valid_q) begin
                    chk("hold_count", int'(count), held_c);
                    chk("hold_overflow", int'(overflow), held_o);
                end else if (busy && !valid) begin
                    cyc++;
                end
                valid_q = valid;
            end
        end
    end

    initial begin
        int wl;
        rst_n = 1'b1; start = 1'b0; win_len = '0; in = 1'b0; ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal window: three 2-high/2-low pulses starting 2 cycles after start.
        clear_pat(); set_pulses(5, 3);
        run_txn(3, 20, 2, 1'b0, 1'b0);
        // Saturation.
        clear_pat(); set_pulses(5, 20);
        run_txn(3, 200, 1, 1'b0, 1'b0);
        // Zero-length window.
        clear_pat();
        run_txn(3, 0, 1, 1'b0, 1'b0);
        // Long hold in DONE with input and start activity.
        clear_pat(); set_pulses(4, 4);
        run_txn(3, 15, 50, 1'b1, 1'b0);
        // Edge in start-accept cycle ignored, edge on last COUNT cycle counted.
        clear_pat();
        for (int i = 1; i <= 9; i++) pat[i] = 1'b1;
        for (int i = 11; i <= 15; i++) pat[i] = 1'b1;
        run_txn(3, 10, 0, 1'b0, 1'b0);

        // Reset in the middle of COUNT after some edges have been counted.
        @(negedge clk);
        start = 1'b1; win_len = WIN_W'(30);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in = 1'(i >> 1);
            @(negedge clk);
        end
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overflow", int'(overflow), 0);
        in = 1'b0;
        repeat (3) @(negedge clk);
        // Start accepted on the very first edge after reset release.
        clear_pat(); pat[2] = 1'b1; pat[3] = 1'b1;
        run_txn(0, 10, 1, 1'b0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            clear_pat();
            wl = $urandom_range(0, 40);
            for (int i = 0; i < wl + 4; i++) pat[i] = 1'($urandom);
            run_txn(3, wl, $urandom_range(0, 5), 1'($urandom), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
